fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Instruction prefetch buffer sitting directly upstream of the IF/ID pipeline register.
//  The unified memory port serves the MEM stage on data accesses. While that port is
//  idle, this block fetches sequential instructions into a small FIFO. It then keeps
//  supplying the IF stage while MEM owns the port, so loads/stores no longer inject NOPs.
//  A taken branch, jal or jalr from MEM flushes the queue and restarts fetch at the target.
// PARAMETERS
//  DEPTH     4      queue entries; power of 2, >= 2
//  XLEN      32     PC and instruction width
//  RESET_PC  32'd0  fetch address after reset
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  mem_free     in   1      1 = memory port available for instruction fetch this cycle (~Using_Mem)
//  mem_fetch_en out  1      1 = block is reading an instruction at mem_addr this cycle
//  mem_addr     out  XLEN   fetch address (= fetch_pc), valid when mem_fetch_en
//  mem_rdata    in   XLEN   instruction word; combinational read of mem_addr, same cycle
//  redirect     in   1      1 = taken control transfer; flush queue
//  redirect_pc  in   XLEN   new fetch address, sampled when redirect=1
//  if_ready     in   1      IF stage accepts head entry this cycle (pipeline not stalled/halted)
//  if_valid     out  1      head entry valid
//  if_inst      out  XLEN   head instruction
//  if_pc        out  XLEN   PC of head instruction
//  count        out  clog2(DEPTH)+1  current occupancy 0..DEPTH
// BEHAVIOUR
//  - State: fetch_pc, rd_ptr, wr_ptr (clog2(DEPTH) bits, wrap mod DEPTH), count, and
//    storage of {pc, inst} per entry. Storage is not reset.
//  - Reset (rst=1 at posedge): fetch_pc<=RESET_PC, ptrs<=0, count<=0.
//    Resulting outputs: if_valid=0, mem_fetch_en=0 while rst=1, count=0.
//  - deq = if_valid & if_ready & ~redirect.
//  - enq = mem_free & ~redirect & ~rst & (count<DEPTH | deq).
//    Full + simultaneous dequeue still enqueues; count stays DEPTH.
//  - mem_fetch_en = enq (combinational); mem_addr = fetch_pc (combinational from register).
//  - On enq: entry[wr_ptr]<={fetch_pc, mem_rdata}; wr_ptr++; fetch_pc<=fetch_pc+4 (mod 2^XLEN).
//  - On deq: rd_ptr++.
//  - count: +1 on enq only, -1 on deq only, unchanged on both or neither.
//  - Outputs: if_valid=(count!=0); if_inst/if_pc = entry[rd_ptr]. Reads are combinational from
//    registered storage. An entry written in cycle N is visible at the head from cycle N+1;
//    there is no same-cycle bypass.
//  - Redirect (priority over everything except rst): ptrs<=0, count<=0,
//    fetch_pc<=redirect_pc. No enq and no deq that cycle.
//    Next cycle: if_valid=0; fetch of redirect_pc occurs in that cycle if mem_free=1.
//    redirect_pc is used as given; no alignment check.
//  - mem_free=0: no fetch. Queue drains at one entry/cycle while if_ready=1.
//    Empty + mem_free=0 -> if_valid=0; the IF stage inserts a NOP.
//  - if_ready=0 with if_valid=1: head entry and outputs hold stable.
//  - Reset asserted mid-operation discards all entries. Any redirect in the same cycle is ignored.
//  - Throughput: 1 instr/cycle sustained when mem_free=1 and if_ready=1.
//    Latency from fetch to if_valid = 1 cycle.
// TESTING
//  1 Reset then mem_free=1, if_ready=0 for 5 cycles -> mem_addr 0,4,8,C; count 1..4;
//    mem_fetch_en=0 in 5th cycle; if_pc=0.
//  2 Full (DEPTH=4), mem_free=1, if_ready=1 -> enq+deq every cycle; count stays 4;
//    if_pc advances 0,4,8,... with no gaps.
//  3 Queue holds 3 entries, mem_free=0 for 4 cycles, if_ready=1 -> 3 instructions
//    delivered, then if_valid=0, count=0, mem_fetch_en=0.
//  4 redirect=1, redirect_pc=0x40 while count=3 and if_ready=1 -> next cycle count=0,
//    if_valid=0, mem_addr=0x40; following cycle if_pc=0x40.
//  5 Enq/deq for 11 cycles to wrap pointers -> if_pc sequence stays in strict +4 order
//    across wrap; if_inst matches memory model at every deq.
//  6 rst=1 together with redirect=1 and count=2 -> fetch_pc=RESET_PC, count=0,
//    redirect_pc ignored.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetch FIFO feeding the IF stage from a shared memory port
module fetch_prefetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_free,
    output logic                     mem_fetch_en,
    output logic [XLEN-1:0]          mem_addr,
    input  logic [XLEN-1:0]          mem_rdata,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     if_ready,
    output logic                     if_valid,
    output logic [XLEN-1:0]          if_inst,
    output logic [XLEN-1:0]          if_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] fetch_pc;

    // storage holds {pc, inst}; contents are only meaningful below count, so no reset
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    logic deq;
    logic enq;

    // handshake decode: redirect kills both sides; a full queue still accepts when the head leaves
    always_comb begin
        deq = if_valid & if_ready & ~redirect;
        enq = mem_free & ~redirect & ~rst & ((count < DEPTH_C) | deq);
    end

    assign mem_fetch_en = enq;
    assign mem_addr     = fetch_pc;
    assign if_valid     = (count != '0);
    assign if_inst      = inst_mem[rd_ptr];
    assign if_pc        = pc_mem[rd_ptr];

    // control state: reset beats redirect, redirect beats normal enqueue/dequeue
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // entry write: the fetched word lands at the tail, visible at the head from the next cycle
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_free;
    logic        mem_fetch_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [2:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit synced = 1'b0;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_free     (mem_free),
        .mem_fetch_en (mem_fetch_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_ready     (if_ready),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .count        (count)
    );

    always #5 clk = ~clk;

    // memory contents: a fixed scramble of the address so every word is distinct
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a queue of fetched {pc, inst} plus the next fetch address
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc = RESET_PC;

    always @(negedge clk) begin
        bit m_deq;
        bit m_enq;
        m_deq = !rst && !redirect && (mq.size() != 0) && if_ready;
        m_enq = !rst && !redirect && mem_free && ((mq.size() < DEPTH) || m_deq);
        if (synced) begin
            chk("model_count", 32'(count), 32'(mq.size()));
            chk("model_if_valid", 32'(if_valid), 32'(mq.size() != 0));
            chk("model_fetch_en", 32'(mem_fetch_en), 32'(m_enq));
            if (m_enq) chk("model_mem_addr", mem_addr, m_fpc);
            if (mq.size() != 0) begin
                chk("model_if_pc", if_pc, mq[0].pc);
                chk("model_if_inst", if_inst, mq[0].inst);
            end
        end
        if (rst) begin
            mq.delete();
            m_fpc = RESET_PC;
        end else if (redirect) begin
            mq.delete();
            m_fpc = redirect_pc;
        end else begin
            if (m_deq) void'(mq.pop_front());
            if (m_enq) begin
                mq.push_back('{m_fpc, mem_word(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic mf, input logic rdy,
                         input logic rd, input logic [31:0] rpc);
        rst         = r;
        mem_free    = mf;
        if_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] mf_pat;
        logic [31:0] rdy_pat;
        logic [31:0] rd_pat;

        rst = 1'b1; mem_free = 1'b1; if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h44;
        @(posedge clk);
        #1;
        synced = 1'b1;
        drive(1, 1, 1, 0, 32'h0);
        chk("reset_fetch_en", 32'(mem_fetch_en), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_if_valid", 32'(if_valid), 32'd0);
        step();

        // fill with the IF stage stalled
        drive(0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("fill_mem_addr", mem_addr, 32'(4 * i));
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_fetch_en", 32'(mem_fetch_en), 32'd1);
            step();
        end
        chk("full_fetch_en", 32'(mem_fetch_en), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_if_pc", if_pc, 32'h0);
        step();
        chk("hold_if_pc", if_pc, 32'h0);
        chk("hold_if_inst", if_inst, mem_word(32'h0));

        // full queue streaming: enqueue and dequeue together
        drive(0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("stream_if_pc", if_pc, 32'(4 * i));
            chk("stream_mem_addr", mem_addr, 32'(16 + 4 * i));
            chk("stream_count", 32'(count), 32'd4);
            chk("stream_fetch_en", 32'(mem_fetch_en), 32'd1);
            step();
        end

        // drop to three entries, then drain with the port busy
        drive(0, 0, 1, 0, 32'h0);
        chk("drain0_if_pc", if_pc, 32'h18);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("drain_if_pc", if_pc, 32'(32'h1C + 4 * i));
            chk("drain_count", 32'(count), 32'(3 - i));
            chk("drain_fetch_en", 32'(mem_fetch_en), 32'd0);
            step();
        end
        chk("empty_if_valid", 32'(if_valid), 32'd0);
        chk("empty_count", 32'(count), 32'd0);
        chk("empty_fetch_en", 32'(mem_fetch_en), 32'd0);
        step();

        // three entries then redirect
        drive(0, 1, 0, 0, 32'h0);
        step(); step(); step();
        chk("pre_redir_count", 32'(count), 32'd3);
        chk("pre_redir_if_pc", if_pc, 32'h28);
        drive(0, 1, 1, 1, 32'h40);
        chk("redir_fetch_en", 32'(mem_fetch_en), 32'd0);
        step();
        drive(0, 1, 1, 0, 32'h0);
        chk("post_redir_count", 32'(count), 32'd0);
        chk("post_redir_if_valid", 32'(if_valid), 32'd0);
        chk("post_redir_mem_addr", mem_addr, 32'h40);
        chk("post_redir_fetch_en", 32'(mem_fetch_en), 32'd1);
        step();

        // pointer wrap at one entry in flight
        for (int i = 0; i < 11; i++) begin
            chk("wrap_if_pc", if_pc, 32'(32'h40 + 4 * i));
            chk("wrap_if_inst", if_inst, mem_word(32'(32'h40 + 4 * i)));
            chk("wrap_count", 32'(count), 32'd1);
            step();
        end

        // reset overrides a simultaneous redirect
        drive(0, 1, 0, 0, 32'h0);
        step();
        chk("pre_rst_count", 32'(count), 32'd2);
        drive(1, 1, 1, 1, 32'h80);
        chk("rst_redir_fetch_en", 32'(mem_fetch_en), 32'd0);
        step();
        drive(0, 1, 0, 0, 32'h0);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_mem_addr", mem_addr, RESET_PC);
        step();
        chk("post_rst_if_pc", if_pc, RESET_PC);

        // mixed directed pattern, model-checked every cycle
        mf_pat  = 32'hF3B7_6DE5;
        rdy_pat = 32'h9E5B_C3A7;
        rd_pat  = 32'h0100_2008;
        for (int i = 0; i < 96; i++) begin
            drive(0, mf_pat[i % 32], rdy_pat[(i * 3) % 32], rd_pat[i % 32],
                  32'(32'h200 + 6 * i));
            step();
        end

        drive(1, 0, 0, 0, 32'h0);
        step();
        chk("final_count", 32'(count), 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
